// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: datapath width, NOP encoding,
// fetch FSM states and next-PC select codes.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_INCR   = 4;

    // FAULT is only reachable when IF_MISALIGN_CHECK_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_INCR     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_gen.sv
// Combinational next-PC select: keep the current PC, step to the next word,
// or take a redirect target. Addition wraps modulo 2^XLEN.
module pc_next_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] redirect_pc,
    input  pc_sel_e         sel,
    output logic [XLEN-1:0] next_pc
);

    // Select the PC for the next cycle.
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_SEL_INCR:     next_pc = pc + XLEN'(PC_INCR);
            PC_SEL_REDIRECT: next_pc = redirect_pc;
            default:         next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory and holds the returned word for the decoder until it is
// consumed. Redirects discard any stale in-flight fetch via the drop flag.
// Optional feature macro: IF_MISALIGN_CHECK_EN (misaligned redirect -> FAULT
// with a sticky fetch_misalign flag). Without it the redirect target is
// word-aligned by clearing its two low bits.
//
// Handshakes: imem request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; the decoder consumes instr on a cycle where
// instr_valid and instr_ready are both high. imem_addr holds while waiting
// for ready unless a redirect changes the PC.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_misalign
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            misalign_q, misalign_d;
    pc_sel_e         pc_sel;
    logic            in_flight;
    logic [XLEN-1:0] redirect_tgt;

`ifdef IF_MISALIGN_CHECK_EN
    logic redirect_bad;
    assign redirect_bad = |redirect_pc[1:0];
    assign redirect_tgt = redirect_pc;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`endif

    pc_next_gen #(.XLEN(XLEN)) u_pc_next_gen (
        .pc          (pc_q),
        .redirect_pc (redirect_tgt),
        .sel         (pc_sel),
        .next_pc     (pc_d)
    );

    // Next-state logic: normal fetch sequencing, then redirect overrides.
    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = misalign_q;
        pc_sel     = PC_SEL_HOLD;
        // A request is still outstanding after this edge if it is accepted
        // now, or was accepted earlier and its response has not arrived.
        in_flight  = ((state_q == S_REQ) && imem_req_ready) ||
                     ((state_q == S_WAIT) && !imem_rsp_valid) ||
                     ((state_q == S_FAULT) && drop_q && !imem_rsp_valid);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d    = imem_rsp_data;
                        instr_pc_d = pc_q;
                        pc_sel     = PC_SEL_INCR;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (instr_ready) state_d = S_REQ;
            end
            S_FAULT: begin
                if (imem_rsp_valid) drop_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid && (state_q != S_IDLE)) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            drop_d     = in_flight;
`ifdef IF_MISALIGN_CHECK_EN
            if (redirect_bad) begin
                misalign_d = 1'b1;
                pc_sel     = PC_SEL_HOLD;
                state_d    = S_FAULT;
            end else begin
                misalign_d = 1'b0;
                pc_sel     = PC_SEL_REDIRECT;
                state_d    = in_flight ? S_WAIT : S_REQ;
            end
`else
            pc_sel  = PC_SEL_REDIRECT;
            state_d = in_flight ? S_WAIT : S_REQ;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == S_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural fetch-stream model with per-cycle
// comparison, an imem responder with programmable latency, and directed
// scenarios with hand-computed literal expectations.
module tb_instr_fetch_unit;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        instr_valid, instr_ready, fetch_misalign;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req_valid, w_rsp_valid, w_instr_valid, w_misalign;
  logic [31:0] w_imem_addr, w_instr, w_instr_pc;
  logic        w_pend;

  int n_checks = 0;
  int n_err    = 0;
  int ecount   = 0;
  int acc_cnt  = 0;
  int cons_cnt = 0;
  int lat      = 1;
  int last_redir_edge = 0;

  logic [31:0] exp_fetch, exp_dec;
  logic        exp_mis, started;
  int          pend_due[$];
  logic [31:0] pend_data[$];
  logic [31:0] req_log[$];
  logic [31:0] cons_pc_q[$];
  int          cons_edge_q[$];
  logic [31:0] w_addr_q[$];

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_misalign(fetch_misalign)
  );

  logic [31:0] w_rsp_data;
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_addr(w_imem_addr), .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .fetch_misalign(w_misalign)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- imem responders ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
      w_rsp_valid    = 1'b0;
      w_pend         = 1'b0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] == ecount) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_data[0];
        void'(pend_due.pop_front());
        void'(pend_data.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      w_rsp_valid = w_pend;
      w_pend      = 1'b0;
    end
  end
  assign w_rsp_data = 32'h0000_0013;

  // ---------------- model + compare (just before each rising edge) ----------------
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      exp_fetch = 32'h0;
      exp_dec   = 32'h0;
      exp_mis   = 1'b0;
      started   = 1'b0;
      pend_due.delete();
      pend_data.delete();
    end else begin
      if (instr_valid) begin
        chk("instr_pc", instr_pc, exp_dec);
        chk("instr", instr, mem_word(exp_dec));
      end
      chk("misalign", {31'b0, fetch_misalign}, {31'b0, exp_mis});
      chk("req_during_hold", {31'b0, imem_req_valid & instr_valid}, 32'h0);
      if (exp_mis) chk("fault_quiet", {30'b0, imem_req_valid, instr_valid}, 32'h0);
      if (imem_req_valid) chk("imem_addr", imem_addr, exp_fetch);
      if (imem_req_valid && imem_req_ready) begin
        chk("one_outstanding", 32'(pend_due.size()), 32'h0);
        pend_due.push_back(ecount + lat);
        pend_data.push_back(mem_word(imem_addr));
        req_log.push_back(imem_addr);
        acc_cnt++;
        exp_fetch = exp_fetch + 32'd4;
      end
      if (instr_valid && instr_ready && !(redirect_valid && started)) begin
        cons_pc_q.push_back(instr_pc);
        cons_edge_q.push_back(ecount);
        cons_cnt++;
        exp_dec = exp_dec + 32'd4;
      end
      if (redirect_valid && started) begin
        last_redir_edge = ecount;
`ifdef IF_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          exp_mis = 1'b1;
        end else begin
          exp_mis   = 1'b0;
          exp_fetch = redirect_pc;
          exp_dec   = redirect_pc;
        end
`else
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_dec   = {redirect_pc[31:2], 2'b00};
`endif
      end
      started = 1'b1;
      if (w_req_valid) begin
        w_addr_q.push_back(w_imem_addr);
        w_pend = 1'b1;
      end
    end
    ecount++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cons(input int n, input string tag);
    int b;
    b = 0;
    while (cons_cnt < n && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (cons_cnt < n) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: consumed %0d needed %0d", tag, cons_cnt, n);
    end
  endtask

  task automatic wait_acc(input string tag);
    int a0, b;
    a0 = acc_cnt;
    b  = 0;
    while (acc_cnt == a0 && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (acc_cnt == a0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: no request accepted", tag);
    end
  endtask

  task automatic wait_sig(input int which, input string tag);
    int b;
    b = 0;
    while (((which == 0) ? !instr_valid : !imem_req_valid) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if ((which == 0) ? !instr_valid : !imem_req_valid) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: signal never rose", tag);
    end
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_misalign"}, {31'b0, fetch_misalign}, 32'h0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_wrap_addr"}, w_imem_addr, 32'hFFFF_FFFC);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, a0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch: 0x0, 0x4, 0x8 consumed every third edge.
    wait_cons(3, "stream");
    if (cons_pc_q.size() >= 3 && req_log.size() >= 3) begin
      chk("stream_pc0", cons_pc_q[0], 32'h0);
      chk("stream_pc1", cons_pc_q[1], 32'h4);
      chk("stream_pc2", cons_pc_q[2], 32'h8);
      chk("stream_gap1", 32'(cons_edge_q[1] - cons_edge_q[0]), 32'd3);
      chk("stream_gap2", 32'(cons_edge_q[2] - cons_edge_q[1]), 32'd3);
      chk("req_addr2", req_log[2], 32'h8);
    end

    // Decoder stall for 5 cycles while holding the word at 0xC.
    instr_ready = 1'b0;
    wait_sig(0, "stall");
    a0 = acc_cnt;
    repeat (5) @(negedge clk);
    chk("stall_valid", {31'b0, instr_valid}, 32'h1);
    chk("stall_pc", instr_pc, 32'hC);
    chk("stall_instr", instr, 32'hC0DE_000C);
    chk("stall_no_req", 32'(acc_cnt), 32'(a0));
    instr_ready = 1'b1;
    wait_cons(4, "stall_release");

    // Redirect in WAIT; the stale response arrives two cycles later.
    lat = 3;
    wait_acc("redir_wait");
    n0 = cons_cnt;
    pulse_redirect(32'h100);
    wait_cons(n0 + 1, "redir_wait");
    chk("redir_wait_pc", cons_pc_q[$], 32'h100);
    chk("redir_wait_req", req_log[$], 32'h100);

    // Redirect on the same edge as the response.
    lat = 1;
    wait_acc("redir_rsp");
    n0 = cons_cnt;
    pulse_redirect(32'h200);
    wait_cons(n0 + 1, "redir_rsp");
    chk("redir_rsp_pc", cons_pc_q[$], 32'h200);
    chk("redir_rsp_latency", 32'(cons_edge_q[$] - last_redir_edge), 32'd3);
    wait_cons(n0 + 2, "redir_rsp_next");
    chk("redir_rsp_next_pc", cons_pc_q[$], 32'h204);

    // Misaligned redirect while HOLD and decoder ready on the same edge.
    wait_sig(0, "misalign");
    n0 = cons_cnt;
    pulse_redirect(32'h102);
`ifdef IF_MISALIGN_CHECK_EN
    a0 = acc_cnt;
    repeat (4) @(negedge clk);
    chk("fault_flag", {31'b0, fetch_misalign}, 32'h1);
    chk("fault_no_req", 32'(acc_cnt), 32'(a0));
    chk("fault_no_instr", 32'(cons_cnt), 32'(n0));
    pulse_redirect(32'h104);
    wait_cons(n0 + 1, "fault_exit");
    chk("fault_exit_pc", cons_pc_q[$], 32'h104);
    chk("fault_exit_flag", {31'b0, fetch_misalign}, 32'h0);
`else
    wait_cons(n0 + 1, "misalign");
    chk("misalign_pc", cons_pc_q[$], 32'h100);
    chk("misalign_req", req_log[$], 32'h100);
`endif

    // Redirect while a request waits for ready.
    imem_req_ready = 1'b0;
    wait_sig(1, "req_stall");
    n0 = cons_cnt;
    pulse_redirect(32'h300);
    chk("req_stall_addr", imem_addr, 32'h300);
    imem_req_ready = 1'b1;
    wait_cons(n0 + 1, "req_stall");
    chk("req_stall_pc", cons_pc_q[$], 32'h300);

    // Wrapping reset PC in the second instance.
    if (w_addr_q.size() >= 2) begin
      chk("wrap_addr0", w_addr_q[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w_addr_q[1], 32'h0000_0000);
    end else begin
      n_checks++;
      n_err++;
      $display("FAIL wrap_reqs: got %0d requests expected 2", w_addr_q.size());
    end

    // Mid-operation asynchronous reset.
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    n0 = cons_cnt;
    wait_cons(n0 + 1, "after_reset");
    chk("after_reset_pc", cons_pc_q[$], 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
